// File: rtl/rf_unit_mp_pkg.sv
// Shared register-file definitions: default geometry, zero register/word and clear FSM states.
package rf_unit_mp_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_DEPTH  = 32;
    localparam int unsigned ZERO_ADDR      = 0;
    localparam logic [63:0] ZERO_WORD      = 64'd0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/rf_unit_mp_read_port.sv
// One combinational read port: zero register, write bypass (wr1 over wr0 over storage), busy masking.
module rf_read_port
    import rf_unit_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              stored_busy,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic [DATA_W-1:0] data_c,
    output logic              busy_c
);

    logic hit0;
    logic hit1;

    assign hit0 = wr0_en && (wr0_addr == addr);
    assign hit1 = wr1_en && (wr1_addr == addr);

    // A value being written this cycle is already available, so it is never reported busy.
    always_comb begin
        data_c = DATA_W'(ZERO_WORD);
        busy_c = 1'b0;
        if (!clear && (addr != ADDR_W'(ZERO_ADDR))) begin
            if (hit1) begin
                data_c = wr1_data;
            end else if (hit0) begin
                data_c = wr0_data;
            end else begin
                data_c = stored_data;
            end
            busy_c = stored_busy && !(hit0 || hit1);
        end
    end

endmodule

// File: rtl/rf_unit_mp.sv
// Multi-port register file with two write ports, pending-write scoreboard and sequential clear engine.
module rf_unit_mp
    import rf_unit_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned NUM_RD = 4,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     rdy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e             state;
    state_e             state_next;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  idx_next;
    logic [DEPTH-1:0]   busy;
    logic [DEPTH-1:0]   busy_next;
    logic               rdy_next;
    logic               idle;
    logic               wr0_act;
    logic               wr1_act;
    logic [DATA_W-1:0]  regs [DEPTH];

    assign idle    = (state == ST_IDLE);
    assign wr0_act = idle && wr0_en;
    assign wr1_act = idle && wr1_en;

    // Control state register; reset always lands in a fresh clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            idx   <= '0;
            busy  <= '0;
            rdy   <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            busy  <= busy_next;
            rdy   <= rdy_next;
        end
    end

    // Clear sequencing and scoreboard update; a set beats a same-cycle write clear.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        busy_next  = busy;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next = ST_CLEAR;
                    idx_next   = '0;
                    busy_next  = '0;
                end else begin
                    if (wr0_en) busy_next[wr0_addr] = 1'b0;
                    if (wr1_en) busy_next[wr1_addr] = 1'b0;
                    if (sb_set_en) busy_next[sb_set_addr] = 1'b1;
                end
            end
            ST_CLEAR: begin
                idx_next = idx + ADDR_W'(1);
                if (idx == LAST_IDX) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_CLEAR;
                idx_next   = '0;
                busy_next  = '0;
            end
        endcase
        busy_next[0] = 1'b0;
        rdy_next     = (state_next == ST_IDLE);
    end

    // Storage has no reset; the clear engine is the only initialiser. wr1 is applied last so it wins.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            regs[idx] <= DATA_W'(ZERO_WORD);
        end else begin
            if (wr0_act && (wr0_addr != ADDR_W'(ZERO_ADDR))) regs[wr0_addr] <= wr0_data;
            if (wr1_act && (wr1_addr != ADDR_W'(ZERO_ADDR))) regs[wr1_addr] <= wr1_data;
        end
    end

    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[i*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .clear       (!idle),
            .addr        (addr),
            .stored_data (regs[addr]),
            .stored_busy (busy[addr]),
            .wr0_en      (wr0_act),
            .wr0_addr    (wr0_addr),
            .wr0_data    (wr0_data),
            .wr1_en      (wr1_act),
            .wr1_addr    (wr1_addr),
            .wr1_data    (wr1_data),
            .data_c      (rd_data[i*DATA_W +: DATA_W]),
            .busy_c      (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_rf_unit_mp.sv
// Scoreboard bench for rf_unit_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_rf_unit_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned NUM_RD = 4;
    localparam int unsigned ADDR_W = 5;

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_RDY  = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     clr_req;
    logic                     rdy;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     sb_set_en;
    logic [ADDR_W-1:0]        sb_set_addr;

    int n_checks = 0;
    int n_fails  = 0;

    string       q_name [$];
    int          q_kind [$];
    int          q_port [$];
    logic [31:0] q_exp  [$];

    rf_unit_mp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_req     (clr_req),
        .rdy         (rdy),
        .wr0_en      (wr0_en),
        .wr0_addr    (wr0_addr),
        .wr0_data    (wr0_data),
        .wr1_en      (wr1_en),
        .wr1_addr    (wr1_addr),
        .wr1_data    (wr1_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string name, input int kind, input int port, input logic [31:0] value);
        q_name.push_back(name);
        q_kind.push_back(kind);
        q_port.push_back(port);
        q_exp.push_back(value);
    endtask

    task automatic set_rd(input int port, input int addr);
        rd_addr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr_req   = 1'b0;
        wr0_en    = 1'b0;
        wr1_en    = 1'b0;
        sb_set_en = 1'b0;
    endtask

    // Monitor: outputs are combinational and settled by the falling edge of the cycle.
    always @(negedge clk) begin
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp_v;
        logic [31:0] act;
        while (q_kind.size() > 0) begin
            name  = q_name.pop_front();
            kind  = q_kind.pop_front();
            port  = q_port.pop_front();
            exp_v = q_exp.pop_front();
            case (kind)
                K_DATA:  act = rd_data[port*DATA_W +: DATA_W];
                K_BUSY:  act = {31'd0, rd_busy[port]};
                default: act = {31'd0, rdy};
            endcase
            n_checks++;
            if (act !== exp_v) begin
                n_fails++;
                $display("FAIL %s port%0d: got 0x%08h expected 0x%08h", name, port, act, exp_v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        idle_inputs();
        wr0_addr    = '0;
        wr0_data    = '0;
        wr1_addr    = '0;
        wr1_data    = '0;
        rd_addr     = '0;
        sb_set_addr = '0;

        // Reset for two cycles.
        tick();
        expect_val("rdy_in_reset", K_RDY, 0, 32'd0);
        tick();

        // Release: exactly 32 cycles of clear with rdy low, then rdy high.
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            expect_val("rdy_clear_after_reset", K_RDY, 0, 32'd0);
            tick();
        end
        expect_val("rdy_after_reset_clear", K_RDY, 0, 32'd1);
        #1;
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fails++;
            $display("FAIL direct_rdy_after_reset: got %b expected 1", rdy);
        end

        // Every register reads 0 and not busy on every port.
        for (int a = 1; a < 32; a++) begin
            for (int p = 0; p < 4; p++) begin
                set_rd(p, a);
                expect_val("post_reset_data", K_DATA, p, 32'd0);
                expect_val("post_reset_busy", K_BUSY, p, 32'd0);
            end
            tick();
        end

        // Write priority: wr1 beats wr0 both in bypass and in storage.
        set_rd(0, 5);
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hAAAA_0001;
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'hBBBB_0002;
        expect_val("prio_bypass", K_DATA, 0, 32'hBBBB_0002);
        expect_val("prio_bypass_busy", K_BUSY, 0, 32'd0);
        #1;
        n_checks++;
        if (rd_data[0 +: DATA_W] !== 32'hBBBB_0002) begin
            n_fails++;
            $display("FAIL direct_prio_bypass: got 0x%08h expected 0xbbbb0002", rd_data[0 +: DATA_W]);
        end
        tick();
        idle_inputs();
        expect_val("prio_stored", K_DATA, 0, 32'hBBBB_0002);
        tick();

        // Zero register ignores writes on both ports.
        set_rd(1, 0);
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFF_FFFF;
        expect_val("zero_same_cycle", K_DATA, 1, 32'd0);
        #1;
        n_checks++;
        if (rd_data[DATA_W +: DATA_W] !== 32'd0) begin
            n_fails++;
            $display("FAIL direct_zero_same_cycle: got 0x%08h expected 0", rd_data[DATA_W +: DATA_W]);
        end
        tick();
        idle_inputs();
        expect_val("zero_later", K_DATA, 1, 32'd0);
        expect_val("zero_busy", K_BUSY, 1, 32'd0);
        tick();

        // Scoreboard set, write-back clear, and set-beats-write.
        set_rd(2, 7);
        sb_set_en = 1'b1; sb_set_addr = 5'd7;
        expect_val("sb_set_cycle_busy", K_BUSY, 2, 32'd0);
        tick();
        idle_inputs();
        expect_val("sb_busy_after_set", K_BUSY, 2, 32'd1);
        tick();
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h0000_1234;
        expect_val("sb_wr_cycle_busy", K_BUSY, 2, 32'd0);
        expect_val("sb_wr_cycle_data", K_DATA, 2, 32'h0000_1234);
        tick();
        idle_inputs();
        expect_val("sb_after_wr_busy", K_BUSY, 2, 32'd0);
        expect_val("sb_after_wr_data", K_DATA, 2, 32'h0000_1234);
        tick();
        sb_set_en = 1'b1; sb_set_addr = 5'd7;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h0000_5678;
        expect_val("sb_set_wr_cycle_busy", K_BUSY, 2, 32'd0);
        expect_val("sb_set_wr_cycle_data", K_DATA, 2, 32'h0000_5678);
        tick();
        idle_inputs();
        expect_val("sb_set_wins_busy", K_BUSY, 2, 32'd1);
        expect_val("sb_set_wins_data", K_DATA, 2, 32'h0000_5678);
        tick();

        // Clear: writes during clear are ignored, a second request does not extend it.
        set_rd(3, 3);
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h0000_0055;
        tick();
        idle_inputs();
        clr_req = 1'b1;
        expect_val("clr_pre_data", K_DATA, 3, 32'h0000_0055);
        expect_val("clr_pre_rdy", K_RDY, 0, 32'd1);
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            idle_inputs();
            if (k == 6) clr_req = 1'b1;
            if (k == 10) begin
                wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h0000_0066;
            end
            expect_val("clr_rdy_low", K_RDY, 0, 32'd0);
            if (k == 10) expect_val("clr_read_zero", K_DATA, 3, 32'd0);
            tick();
        end
        idle_inputs();
        expect_val("clr_done_rdy", K_RDY, 0, 32'd1);
        expect_val("clr_addr3_zero", K_DATA, 3, 32'd0);
        expect_val("clr_busy7_zero", K_BUSY, 2, 32'd0);
        expect_val("clr_addr7_zero", K_DATA, 2, 32'd0);
        tick();

        // Reset at clear cycle 10 restarts a full clear; a clr_req inside it is ignored.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            expect_val("rst_mid_rdy_low", K_RDY, 0, 32'd0);
            tick();
        end
        rst_n = 1'b0;
        expect_val("rst_mid_rdy_in_rst", K_RDY, 0, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            clr_req = (k == 3);
            expect_val("restart_rdy_low", K_RDY, 0, 32'd0);
            tick();
        end
        clr_req = 1'b0;
        set_rd(0, 5);
        expect_val("restart_rdy_high", K_RDY, 0, 32'd1);
        expect_val("restart_addr5_zero", K_DATA, 0, 32'd0);
        tick();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
